// File: rtl/ps2_mouse_packet_decoder.sv
// ============================================================================
//  Module   : ps2_mouse_packet_decoder
//  Purpose  : Aligns PS/2 mouse bytes into packets, decodes buttons and X/Y
//             movement, and holds each packet until the consumer reads it.
//             Define PS2_MOUSE_WHEEL_EN for 4-byte IntelliMouse packets.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_mouse_packet_decoder #(
    parameter int TIMEOUT_CYCLES = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic       left_button,
    output logic       right_button,
    output logic       middle_button,
    output logic [8:0] x_increment,
    output logic [8:0] y_increment,
`ifdef PS2_MOUSE_WHEEL_EN
    output logic [3:0] wheel_increment,
`endif
    output logic       data_ready,
    input  logic       read,
    output logic       sync_error,
    output logic       overrun
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        BYTE0 = 2'd0,
        BYTE1 = 2'd1,
`ifdef PS2_MOUSE_WHEEL_EN
        BYTE2 = 2'd2,
        BYTE3 = 2'd3
`else
        BYTE2 = 2'd2
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Header byte without bit3, which is always 1 once aligned.
    logic [6:0]         hdr_q, hdr_d;
    logic [7:0]         byte1_q, byte1_d;
`ifdef PS2_MOUSE_WHEEL_EN
    logic [7:0]         byte2_q, byte2_d;
    logic [3:0]         wheel_q, wheel_d;
`endif
    logic [2:0]         btn_q, btn_d;
    logic [8:0]         x_q, x_d;
    logic [8:0]         y_q, y_d;
    logic               ready_q, ready_d;
    logic               sync_q, sync_d;
    logic               ovr_q, ovr_d;

    logic               timeout;
    logic               complete;
    state_t             eff_state;
    logic [7:0]         y_byte;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BYTE0;
            cnt_q   <= '0;
            hdr_q   <= '0;
            byte1_q <= '0;
`ifdef PS2_MOUSE_WHEEL_EN
            byte2_q <= '0;
            wheel_q <= '0;
`endif
            btn_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            ready_q <= 1'b0;
            sync_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hdr_q   <= hdr_d;
            byte1_q <= byte1_d;
`ifdef PS2_MOUSE_WHEEL_EN
            byte2_q <= byte2_d;
            wheel_q <= wheel_d;
`endif
            btn_q   <= btn_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ready_q <= ready_d;
            sync_q  <= sync_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hdr_d    = hdr_q;
        byte1_d  = byte1_q;
`ifdef PS2_MOUSE_WHEEL_EN
        byte2_d  = byte2_q;
        wheel_d  = wheel_q;
        y_byte   = byte2_q;
`else
        y_byte   = rx_byte;
`endif
        btn_d    = btn_q;
        x_d      = x_q;
        y_d      = y_q;
        ready_d  = ready_q;
        sync_d   = 1'b0;
        ovr_d    = 1'b0;
        complete = 1'b0;

        timeout   = (state_q != BYTE0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
        // A byte landing on the expiry cycle is judged as a fresh header.
        eff_state = timeout ? BYTE0 : state_q;

        if (timeout) begin
            sync_d  = 1'b1;
            state_d = BYTE0;
            cnt_d   = '0;
        end else if (state_q != BYTE0 && !rx_valid) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (rx_valid) begin
            cnt_d = '0;
            case (eff_state)
                BYTE0: begin
                    if (rx_byte[3]) begin
                        hdr_d   = {rx_byte[7:4], rx_byte[2:0]};
                        state_d = BYTE1;
                    end else begin
                        sync_d  = 1'b1;
                        state_d = BYTE0;
                    end
                end
                BYTE1: begin
                    byte1_d = rx_byte;
                    state_d = BYTE2;
                end
`ifdef PS2_MOUSE_WHEEL_EN
                BYTE2: begin
                    byte2_d = rx_byte;
                    state_d = BYTE3;
                end
                BYTE3: begin
                    complete = 1'b1;
                    state_d  = BYTE0;
                end
`else
                BYTE2: begin
                    complete = 1'b1;
                    state_d  = BYTE0;
                end
                default: state_d = BYTE0;
`endif
            endcase
        end

        if (complete) begin
            if (!ready_q || read) begin
                ready_d = 1'b1;
                btn_d   = hdr_q[2:0];
                // hdr_q: [6]=Y ovf, [5]=X ovf, [4]=Y sign, [3]=X sign
                x_d     = hdr_q[5] ? (hdr_q[3] ? 9'h100 : 9'h0FF) : {hdr_q[3], byte1_q};
                y_d     = hdr_q[6] ? (hdr_q[4] ? 9'h100 : 9'h0FF) : {hdr_q[4], y_byte};
`ifdef PS2_MOUSE_WHEEL_EN
                wheel_d = rx_byte[3:0];
`endif
            end else begin
                ovr_d = 1'b1;
            end
        end else if (read) begin
            ready_d = 1'b0;
        end
    end

    assign left_button     = btn_q[0];
    assign right_button    = btn_q[1];
    assign middle_button   = btn_q[2];
    assign x_increment     = x_q;
    assign y_increment     = y_q;
`ifdef PS2_MOUSE_WHEEL_EN
    assign wheel_increment = wheel_q;
`endif
    assign data_ready      = ready_q;
    assign sync_error      = sync_q;
    assign overrun         = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_mouse_packet_decoder.sv
// ============================================================================
//  Module   : tb_ps2_mouse_packet_decoder
//  Purpose  : Self-checking bench for ps2_mouse_packet_decoder (directed plus
//             random traffic against a packet-level reference model).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_mouse_packet_decoder;

    localparam int T = 40;
`ifdef PS2_MOUSE_WHEEL_EN
    localparam int PKT_LEN = 4;
`else
    localparam int PKT_LEN = 3;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       read;
    logic       left_button, right_button, middle_button;
    logic [8:0] x_increment, y_increment;
    logic [3:0] wheel_obs;
    logic       data_ready, sync_error, overrun;

    ps2_mouse_packet_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_byte         (rx_byte),
        .rx_valid        (rx_valid),
        .left_button     (left_button),
        .right_button    (right_button),
        .middle_button   (middle_button),
        .x_increment     (x_increment),
        .y_increment     (y_increment),
`ifdef PS2_MOUSE_WHEEL_EN
        .wheel_increment (wheel_obs),
`endif
        .data_ready      (data_ready),
        .read            (read),
        .sync_error      (sync_error),
        .overrun         (overrun)
    );

`ifndef PS2_MOUSE_WHEEL_EN
    assign wheel_obs = 4'h0;
`endif

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: partial packet as a byte queue plus silence counter.
    logic [7:0] part[$];
    int         idle;
    logic       m_dr, m_sync, m_ovr;
    logic [2:0] m_btn;
    logic [8:0] m_x, m_y;
    logic [3:0] m_w;

    function automatic logic [8:0] axis(input logic ovf, input logic sgn, input logic [7:0] mag);
        int v;
        if (ovf) v = sgn ? -256 : 255;
        else     v = int'(mag) - (sgn ? 256 : 0);
        return v[8:0];
    endfunction

    task automatic model_reset();
        part.delete();
        idle = 0; m_dr = 0; m_sync = 0; m_ovr = 0;
        m_btn = 0; m_x = 0; m_y = 0; m_w = 0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] b, input logic rd);
        logic done;
        done   = 0;
        m_sync = 0;
        m_ovr  = 0;
        if (part.size() > 0 && idle == T) begin
            part.delete();
            m_sync = 1;
            idle   = 0;
        end
        if (v) begin
            if (part.size() == 0) begin
                if (b[3]) part.push_back(b);
                else      m_sync = 1;
            end else begin
                part.push_back(b);
            end
            idle = 0;
            if (part.size() == PKT_LEN) done = 1;
        end else if (part.size() > 0) begin
            idle++;
        end
        if (done) begin
            if (!m_dr || rd) begin
                m_dr  = 1;
                m_btn = part[0][2:0];
                m_x   = axis(part[0][6], part[0][4], part[1]);
                m_y   = axis(part[0][7], part[0][5], part[2]);
                m_w   = (PKT_LEN == 4) ? part[PKT_LEN-1][3:0] : 4'h0;
            end else begin
                m_ovr = 1;
            end
            part.delete();
        end else if (rd) begin
            m_dr = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("data_ready", 32'(data_ready), 32'(m_dr));
        chk("sync_error", 32'(sync_error), 32'(m_sync));
        chk("overrun",    32'(overrun),    32'(m_ovr));
        chk("buttons",    32'({middle_button, right_button, left_button}), 32'(m_btn));
        chk("x_inc",      32'(x_increment), 32'(m_x));
        chk("y_inc",      32'(y_increment), 32'(m_y));
        chk("wheel",      32'(wheel_obs),   32'(m_w));
    endtask

    task automatic cyc(input logic v, input logic [7:0] b, input logic rd);
        rx_valid = v;
        rx_byte  = b;
        read     = rd;
        @(posedge clk);
        model_step(v, b, rd);
        #1;
        check_all();
        rx_valid = 1'b0;
        read     = 1'b0;
    endtask

    // Sends a packet; the wheel byte is appended only in 4-byte builds.
    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input logic rd_last);
        cyc(1, b0, 0);
        cyc(1, b1, 0);
        if (PKT_LEN == 4) begin
            cyc(1, b2, 0);
            cyc(1, b3, rd_last);
        end else begin
            cyc(1, b2, rd_last);
        end
    endtask

    initial begin
        int syncs;
        int ovrs;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        read     = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dr",   32'(data_ready), 32'd0);
        chk("rst_sync", 32'(sync_error), 32'd0);
        chk("rst_ovr",  32'(overrun),    32'd0);
        chk("rst_x",    32'(x_increment), 32'd0);
        chk("rst_y",    32'(y_increment), 32'd0);
        reset = 1'b0;
        cyc(0, 0, 0);

        // Basic packet and read handshake
        send_pkt(8'h09, 8'h05, 8'hFD, 8'h00, 0);
        chk("tp1_dr",   32'(data_ready), 32'd1);
        chk("tp1_left", 32'(left_button), 32'd1);
        chk("tp1_x",    32'(x_increment), 32'h005);
        chk("tp1_y",    32'(y_increment), 32'h0FD);
        cyc(0, 0, 1);
        chk("tp1_rd",   32'(data_ready), 32'd0);

        // Misaligned header then a negative-X packet
        cyc(1, 8'h02, 0);
        chk("tp2_sync", 32'(sync_error), 32'd1);
        send_pkt(8'h18, 8'hF0, 8'h10, 8'h00, 0);
        chk("tp2_x", 32'(x_increment), 32'h1F0);
        chk("tp2_y", 32'(y_increment), 32'h010);
        cyc(0, 0, 1);

        // Timeout after a lone header
        cyc(1, 8'h08, 0);
        syncs = 0;
        for (int i = 0; i < T + 3; i++) begin
            cyc(0, 0, 0);
            if (sync_error) syncs++;
        end
        chk("tp3_sync_count", 32'(syncs), 32'd1);
        send_pkt(8'h08, 8'h01, 8'h01, 8'h00, 0);
        chk("tp3_x", 32'(x_increment), 32'h001);
        chk("tp3_y", 32'(y_increment), 32'h001);
        cyc(0, 0, 1);

        // Byte arriving on the exact expiry cycle is taken as a new header
        cyc(1, 8'h08, 0);
        for (int i = 0; i < T; i++) cyc(0, 0, 0);
        cyc(1, 8'h08, 0);
        chk("exp_sync", 32'(sync_error), 32'd1);
        cyc(1, 8'h02, 0);
        if (PKT_LEN == 4) cyc(1, 8'h03, 0);
        cyc(1, (PKT_LEN == 4) ? 8'h00 : 8'h03, 0);
        chk("exp_dr", 32'(data_ready), 32'd1);
        chk("exp_x",  32'(x_increment), 32'h002);
        chk("exp_y",  32'(y_increment), 32'h003);
        cyc(0, 0, 1);

        // X overflow saturation, negative direction
        send_pkt(8'h58, 8'h00, 8'h00, 8'h00, 0);
        chk("tp4_x", 32'(x_increment), 32'h100);
        chk("tp4_y", 32'(y_increment), 32'h000);
        cyc(0, 0, 1);
        send_pkt(8'h88, 8'h00, 8'h00, 8'h00, 0);
        chk("ovf_y_pos", 32'(y_increment), 32'h0FF);
        cyc(0, 0, 1);

        // Overrun: second packet dropped
        send_pkt(8'h09, 8'h11, 8'h22, 8'h00, 0);
        ovrs = 0;
        cyc(1, 8'h0A, 0);
        cyc(1, 8'h33, 0);
        if (PKT_LEN == 4) cyc(1, 8'h44, 0);
        cyc(1, 8'h55, 0);
        if (overrun) ovrs++;
        cyc(0, 0, 0);
        if (overrun) ovrs++;
        chk("tp5_ovr_count", 32'(ovrs), 32'd1);
        chk("tp5_keep_x",    32'(x_increment), 32'h011);
        // Read coincident with completion loads the new packet
        send_pkt(8'h0C, 8'h66, 8'h77, 8'h00, 1);
        chk("tp5_dr",   32'(data_ready), 32'd1);
        chk("tp5_x",    32'(x_increment), 32'h066);
        chk("tp5_ovr",  32'(overrun), 32'd0);
        cyc(0, 0, 1);

`ifdef PS2_MOUSE_WHEEL_EN
        send_pkt(8'h08, 8'h00, 8'h00, 8'h0F, 0);
        chk("tp6_wheel", 32'(wheel_obs), 32'hF);
        cyc(0, 0, 1);
`endif

        // Asynchronous reset mid-packet with a held packet
        send_pkt(8'h0F, 8'h12, 8'h34, 8'h05, 0);
        cyc(1, 8'h08, 0);
        cyc(1, 8'h01, 0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("arst_dr", 32'(data_ready), 32'd0);
        chk("arst_x",  32'(x_increment), 32'd0);
        chk("arst_btn", 32'({middle_button, right_button, left_button}), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        send_pkt(8'h0A, 8'h03, 8'h04, 8'h00, 0);
        chk("arst_restart_x", 32'(x_increment), 32'h003);
        cyc(0, 0, 1);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                cyc(1, 8'($urandom) & 8'hF7, $urandom_range(0, 3) == 0);
            end else if (kind == 1) begin
                cyc(1, 8'($urandom) | 8'h08, 0);
                if ($urandom_range(0, 1) == 1) cyc(1, 8'($urandom), 0);
                for (int i = 0; i < T + int'($urandom_range(0, 3)); i++)
                    cyc(0, 0, $urandom_range(0, 7) == 0);
            end else begin
                for (int k = 0; k < PKT_LEN; k++) begin
                    logic [7:0] b;
                    b = 8'($urandom);
                    if (k == 0) b = b | 8'h08;
                    cyc(1, b, $urandom_range(0, 3) == 0);
                    for (int g = 0; g < int'($urandom_range(0, 2)); g++)
                        cyc(0, 0, $urandom_range(0, 3) == 0);
                end
            end
            for (int g = 0; g < int'($urandom_range(0, 2)); g++)
                cyc(0, 0, $urandom_range(0, 2) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
